// File: rtl/coproc_scheduler.sv
`timescale 1ns/1ps
// coproc_scheduler
//   Two-requester round-robin scheduler for the shared matrix coprocessor and
//   its 4-word x 200-bit operand memory. Requester 0 is the HPS bridge and
//   requester 1 is the debug/test port. A granted command is written to
//   memory (instruction, A, B), the control unit is started, completion is
//   awaited (with timeout), the result word is read back and returned to the
//   granted requester.
//
// Ports
//   clk, rst       clock, asynchronous active-low reset
//   req            per-requester request level (bit i = requester i)
//   req_opcode     {op1[2:0], op0[2:0]}
//   req_msize      {ms1[1:0], ms0[1:0]}
//   req_mat_a/b    {mat1[199:0], mat0[199:0]}
//   rsp_valid      one-cycle completion pulse, one-hot to the served requester
//   rsp_data/ovf/err  result word, overflow flag, timeout flag (held until next response)
//   busy           high from the cycle after grant through the response cycle
//   mem_own        scheduler owns the memory port (mux select)
//   mem_addr/wdata/wren/rdata  operand memory port
//   cp_start       start to the control unit
//   cp_ready       control unit ready level
//   cp_overflow    control unit overflow flag
module coproc_scheduler #(
  parameter int unsigned START_CYCLES   = 4,
  parameter int unsigned RD_LAT         = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     req,
  input  logic [5:0]     req_opcode,
  input  logic [3:0]     req_msize,
  input  logic [399:0]   req_mat_a,
  input  logic [399:0]   req_mat_b,
  output logic [1:0]     rsp_valid,
  output logic [199:0]   rsp_data,
  output logic           rsp_ovf,
  output logic           rsp_err,
  output logic           busy,
  output logic           mem_own,
  output logic [1:0]     mem_addr,
  output logic [199:0]   mem_wdata,
  output logic           mem_wren,
  input  logic [199:0]   mem_rdata,
  output logic           cp_start,
  input  logic           cp_ready,
  input  logic           cp_overflow
);

  // One shared counter serves START, WAIT and RD; size it for the longest phase.
  localparam int unsigned MaxA   = (START_CYCLES > RD_LAT) ? START_CYCLES : RD_LAT;
  localparam int unsigned MaxCnt = (MaxA > TIMEOUT_CYCLES) ? MaxA : TIMEOUT_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  localparam logic [CntW-1:0] StartLast   = CntW'(START_CYCLES - 1);
  localparam logic [CntW-1:0] RdLast      = CntW'(RD_LAT - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWrIns,
    StWrA,
    StWrB,
    StStart,
    StWait,
    StRd,
    StResp
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            grant_q, grant_d;
  logic            last_q, last_d;      // requester served last
  logic [2:0]      opcode_q, opcode_d;
  logic [1:0]      msize_q, msize_d;
  logic [199:0]    mat_a_q, mat_a_d;
  logic [199:0]    mat_b_q, mat_b_d;
  logic            ready_q, ready_d;    // registered cp_ready for edge detection
  logic            comp_ovf_q, comp_ovf_d;
  logic [199:0]    data_q, data_d;
  logic            rsp_ovf_q, rsp_ovf_d;
  logic            rsp_err_q, rsp_err_d;

  logic            gsel;
  logic            done_edge;

  assign done_edge = cp_ready & ~ready_q;

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    grant_d    = grant_q;
    last_d     = last_q;
    opcode_d   = opcode_q;
    msize_d    = msize_q;
    mat_a_d    = mat_a_q;
    mat_b_d    = mat_b_q;
    ready_d    = cp_ready;
    comp_ovf_d = comp_ovf_q;
    data_d     = data_q;
    rsp_ovf_d  = rsp_ovf_q;
    rsp_err_d  = rsp_err_q;
    // Tie goes to the requester not served last; a lone request wins outright.
    gsel       = (req == 2'b11) ? ~last_q : req[1];

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (|req) begin
          grant_d  = gsel;
          opcode_d = gsel ? req_opcode[5:3]     : req_opcode[2:0];
          msize_d  = gsel ? req_msize[3:2]      : req_msize[1:0];
          mat_a_d  = gsel ? req_mat_a[399:200]  : req_mat_a[199:0];
          mat_b_d  = gsel ? req_mat_b[399:200]  : req_mat_b[199:0];
          state_d  = StWrIns;
        end
      end
      StWrIns: state_d = StWrA;
      StWrA:   state_d = StWrB;
      StWrB: begin
        cnt_d   = '0;
        state_d = StStart;
      end
      StStart: begin
        if (cnt_q == StartLast) begin
          cnt_d   = '0;
          state_d = StWait;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWait: begin
        if (done_edge) begin
          comp_ovf_d = cp_overflow;
          cnt_d      = '0;
          state_d    = StRd;
        end else if (cnt_q == TimeoutLast) begin
          data_d    = '0;
          rsp_ovf_d = 1'b0;
          rsp_err_d = 1'b1;
          state_d   = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRd: begin
        if (cnt_q == RdLast) begin
          data_d    = mem_rdata;
          rsp_ovf_d = comp_ovf_q;
          rsp_err_d = 1'b0;
          state_d   = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        last_d  = grant_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    rsp_valid = 2'b00;
    busy      = 1'b0;
    mem_own   = 1'b0;
    mem_addr  = 2'd0;
    mem_wdata = '0;
    mem_wren  = 1'b0;
    cp_start  = 1'b0;
    rsp_data  = data_q;
    rsp_ovf   = rsp_ovf_q;
    rsp_err   = rsp_err_q;

    unique case (state_q)
      StIdle: ;
      StWrIns: begin
        busy      = 1'b1;
        mem_own   = 1'b1;
        mem_wren  = 1'b1;
        mem_addr  = 2'd0;
        mem_wdata = {184'b0, 5'b0, opcode_q, 6'b0, msize_q};
      end
      StWrA: begin
        busy      = 1'b1;
        mem_own   = 1'b1;
        mem_wren  = 1'b1;
        mem_addr  = 2'd1;
        mem_wdata = mat_a_q;
      end
      StWrB: begin
        busy      = 1'b1;
        mem_own   = 1'b1;
        mem_wren  = 1'b1;
        mem_addr  = 2'd2;
        mem_wdata = mat_b_q;
      end
      StStart: begin
        busy     = 1'b1;
        cp_start = 1'b1;
      end
      StWait: busy = 1'b1;
      StRd: begin
        busy     = 1'b1;
        mem_own  = 1'b1;
        mem_addr = 2'd3;
      end
      StResp: begin
        busy      = 1'b1;
        rsp_valid = grant_q ? 2'b10 : 2'b01;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      grant_q    <= 1'b0;
      last_q     <= 1'b1;  // so requester 0 wins the first tie
      opcode_q   <= '0;
      msize_q    <= '0;
      mat_a_q    <= '0;
      mat_b_q    <= '0;
      ready_q    <= 1'b0;
      comp_ovf_q <= 1'b0;
      data_q     <= '0;
      rsp_ovf_q  <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      opcode_q   <= opcode_d;
      msize_q    <= msize_d;
      mat_a_q    <= mat_a_d;
      mat_b_q    <= mat_b_d;
      ready_q    <= ready_d;
      comp_ovf_q <= comp_ovf_d;
      data_q     <= data_d;
      rsp_ovf_q  <= rsp_ovf_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_coproc_scheduler.sv
`timescale 1ns/1ps
// Bench for coproc_scheduler: directed scenarios, operand memory and control
// unit models, scoreboard of expected responses checked by a monitor.
module tb_coproc_scheduler;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [1:0]   req = '0;
  logic [5:0]   req_opcode = '0;
  logic [3:0]   req_msize = '0;
  logic [399:0] req_mat_a = '0;
  logic [399:0] req_mat_b = '0;
  logic [1:0]   rsp_valid;
  logic [199:0] rsp_data;
  logic         rsp_ovf, rsp_err, busy, mem_own, mem_wren, cp_start;
  logic [1:0]   mem_addr;
  logic [199:0] mem_wdata, mem_rdata;
  logic         cp_ready = 1'b0;
  logic         cp_overflow = 1'b0;

  always #5 clk = ~clk;

  coproc_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_opcode  (req_opcode),
    .req_msize   (req_msize),
    .req_mat_a   (req_mat_a),
    .req_mat_b   (req_mat_b),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_ovf     (rsp_ovf),
    .rsp_err     (rsp_err),
    .busy        (busy),
    .mem_own     (mem_own),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wren    (mem_wren),
    .mem_rdata   (mem_rdata),
    .cp_start    (cp_start),
    .cp_ready    (cp_ready),
    .cp_overflow (cp_overflow)
  );

  // Operand memory: word 3 is the control unit's result, two-cycle read.
  logic [199:0] mem [4];
  logic [199:0] result_word = '0;
  logic [1:0]   rd_addr_q;
  int unsigned  cyc = 0;

  always @(posedge clk) begin
    if (mem_own && mem_wren) mem[mem_addr] <= mem_wdata;
    rd_addr_q <= mem_addr;
    cyc       <= cyc + 1;
  end
  assign mem_rdata = (rd_addr_q == 2'd3) ? result_word : mem[rd_addr_q];

  typedef struct packed {
    logic [1:0]   valid;
    logic [199:0] data;
    logic         ovf;
    logic         err;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t mon_e;
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] v, input logic [199:0] d, input logic o, input logic e);
    rsp_t x;
    x.valid = v;
    x.data  = d;
    x.ovf   = o;
    x.err   = e;
    exp_q.push_back(x);
  endtask

  function automatic logic [199:0] ins_word(input logic [2:0] op, input logic [1:0] ms);
    return {184'b0, 5'b0, op, 6'b0, ms};
  endfunction

  function automatic logic [511:0] all_outs();
    return 512'({rsp_valid, rsp_data, rsp_ovf, rsp_err, busy, mem_own, mem_addr,
                 mem_wdata, mem_wren, cp_start});
  endfunction

  // Monitor: every response is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (mem_wren) chk("wren_without_own", 512'(mem_own), 512'd1);
    if (rsp_valid != 2'b00) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 512'(rsp_valid), 512'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_valid", 512'(rsp_valid), 512'(mon_e.valid));
        chk("rsp_data", 512'(rsp_data), 512'(mon_e.data));
        chk("rsp_ovf", 512'(rsp_ovf), 512'(mon_e.ovf));
        chk("rsp_err", 512'(rsp_err), 512'(mon_e.err));
        chk("busy_at_rsp", 512'(busy), 512'd1);
      end
    end
  end

  // Control unit model. With toggle set, ready drops at start and rises k
  // cycles after start ends; otherwise ready is left untouched. Returns on the
  // negedge where the ready edge is presented (or the first WAIT cycle).
  task automatic serve(input int k, input logic ovf, input logic [199:0] r,
                       input bit toggle, output int start_len);
    int n;
    n = 0;
    start_len = 0;
    while (!cp_start && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!cp_start) begin
      chk("start_seen", 512'd0, 512'd1);
      return;
    end
    if (toggle) cp_ready = 1'b0;
    result_word = r;
    while (cp_start && start_len < 60) begin
      start_len++;
      @(negedge clk);
    end
    if (toggle) begin
      repeat (k - 1) @(negedge clk);
      cp_ready    = 1'b1;
      cp_overflow = ovf;
    end
  endtask

  task automatic wait_rsp(input int bound, output int unsigned t);
    int n;
    n = 0;
    while (rsp_valid == 2'b00 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (rsp_valid == 2'b00) chk("rsp_arrived", 512'd0, 512'd1);
    t = cyc;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [199:0] A0 = {25{8'hA1}};
  localparam logic [199:0] B0 = {25{8'hB1}};
  localparam logic [199:0] A1 = {25{8'hA2}};
  localparam logic [199:0] B1 = {25{8'hB2}};

  initial begin
    int          slen;
    int unsigned t0, t1;
    logic [199:0] r;
    logic [199:0] a_exp;
    bit          wren_seen;

    // Reset state
    #1 chk("reset_outputs", all_outs(), 512'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // 1: single op from requester 0, write sequence and latency
    @(negedge clk);
    req_opcode = {3'b000, 3'b000};
    req_msize  = {2'b00, 2'b11};
    req_mat_a  = {A1, A0};
    req_mat_b  = {B1, B0};
    req        = 2'b01;
    r          = {25{8'hC1}};
    push(2'b01, r, 1'b0, 1'b0);
    @(negedge clk);
    t0 = cyc;
    chk("busy_after_grant", 512'(busy), 512'd1);
    chk("wr_ins", 512'({mem_own, mem_wren, mem_addr, mem_wdata}),
        512'({1'b1, 1'b1, 2'd0, 200'h3}));
    @(negedge clk);
    chk("wr_a", 512'({mem_own, mem_wren, mem_addr, mem_wdata}), 512'({1'b1, 1'b1, 2'd1, A0}));
    @(negedge clk);
    chk("wr_b", 512'({mem_own, mem_wren, mem_addr, mem_wdata}), 512'({1'b1, 1'b1, 2'd2, B0}));
    serve(2, 1'b0, r, 1'b1, slen);
    chk("start_len_t1", 512'(slen), 512'd4);
    wait_rsp(40, t1);
    req = 2'b00;
    chk("latency_k2", 512'(t1 - t0), 512'd11);

    // 2: contention with req held; grants alternate 0,1,0,1 after reset
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    req_opcode = {3'b010, 3'b101};
    req_msize  = {2'b10, 2'b01};
    req        = 2'b11;
    for (int i = 0; i < 4; i++) begin
      r = {25{8'(8'hD0 + i)}};
      push((i % 2 == 0) ? 2'b01 : 2'b10, r, 1'b0, 1'b0);
      serve(1 + i, 1'b0, r, 1'b1, slen);
      chk("start_len_rr", 512'(slen), 512'd4);
      a_exp = (i % 2 == 0) ? A0 : A1;
      chk("rr_mem_a", 512'(mem[1]), 512'(a_exp));
      chk("rr_mem_ins", 512'(mem[0]),
          512'((i % 2 == 0) ? ins_word(3'b101, 2'b01) : ins_word(3'b010, 2'b10)));
      wait_rsp(40, t1);
      if (i == 3) req = 2'b00;
    end

    // 3: ready stuck high, no edge: timeout after 1024 WAIT cycles
    @(negedge clk);
    req = 2'b01;
    push(2'b01, 200'd0, 1'b0, 1'b1);
    serve(1, 1'b0, {25{8'hEE}}, 1'b0, slen);
    t0 = cyc;
    wren_seen = 1'b0;
    for (int n = 0; n < 1100 && rsp_valid == 2'b00; n++) begin
      @(negedge clk);
      wren_seen |= mem_wren;
    end
    t1 = cyc;
    req = 2'b00;
    chk("timeout_len", 512'(t1 - t0), 512'd1024);
    chk("wren_during_wait", 512'(wren_seen), 512'd0);

    // 4: overflow reported then cleared on the next op
    @(negedge clk);
    req = 2'b10;
    r   = {25{8'h5A}};
    push(2'b10, r, 1'b1, 1'b0);
    serve(3, 1'b1, r, 1'b1, slen);
    wait_rsp(40, t1);
    req = 2'b00;
    @(negedge clk);
    req = 2'b01;
    r   = {25{8'h3C}};
    push(2'b01, r, 1'b0, 1'b0);
    serve(1, 1'b0, r, 1'b1, slen);
    wait_rsp(40, t1);
    req = 2'b00;

    // 5: async reset during WAIT aborts silently; then requester 1 alone
    @(negedge clk);
    req = 2'b01;
    serve(1, 1'b0, {25{8'h77}}, 1'b0, slen);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    req = 2'b00;
    #1 chk("async_reset_outputs", all_outs(), 512'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    req = 2'b10;
    r   = {25{8'h99}};
    push(2'b10, r, 1'b0, 1'b0);
    serve(2, 1'b0, r, 1'b1, slen);
    chk("post_reset_mem_b", 512'(mem[2]), 512'(B1));
    wait_rsp(40, t1);
    req = 2'b00;

    // 6: req0 dropped during WR_A, command changed; latched values used
    @(negedge clk);
    req_opcode = {3'b000, 3'b110};
    req_msize  = {2'b00, 2'b10};
    req_mat_a  = {A1, {25{8'h61}}};
    req_mat_b  = {B1, {25{8'h62}}};
    req        = 2'b01;
    r          = {25{8'h42}};
    push(2'b01, r, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    req        = 2'b00;
    req_mat_a  = '1;
    req_mat_b  = '1;
    req_opcode = '0;
    serve(1, 1'b0, r, 1'b1, slen);
    chk("drop_mem_a", 512'(mem[1]), 512'({25{8'h61}}));
    chk("drop_mem_b", 512'(mem[2]), 512'({25{8'h62}}));
    chk("drop_mem_ins", 512'(mem[0]), 512'(ins_word(3'b110, 2'b10)));
    wait_rsp(40, t1);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 512'(exp_q.size()), 512'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
